mult_share_ctrl: RTL and testbench
==================================

# mult_share_ctrl

Multi-cycle issue controller that shares one combinational 8x8 Wallace multiplier core among `N_REQ` requesters. It arbitrates incoming operand pairs round-robin and drives the core's operand inputs from registers. It waits a fixed settle window, then captures the 16-bit product and returns it on a single response channel tagged with the requester index. The block sits between the requester-side logic and the multiplier core, which is instantiated outside this block.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters; legal range 2..16.
- `SETTLE_CYC`, default 2: number of cycles the core output is allowed to settle before capture; legal range 1..15.
- `ID_W`, default `$clog2(N_REQ)`: width of the response tag.

Ports:
- `clk`  in  1: single clock; all state on rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `req_valid`  in  N_REQ: per-requester operand valid.
- `req_ready`  out  N_REQ: per-requester accept. At most one bit is high; it is combinational from `req_valid` and state.
- `req_a`  in  8*N_REQ: packed multiplicands; requester i occupies bits [8i+7:8i].
- `req_b`  in  8*N_REQ: packed multipliers, same packing as `req_a`.
- `mul_a`  out  8: registered operand A to the multiplier core.
- `mul_b`  out  8: registered operand B to the multiplier core.
- `mul_p`  in  16: product from the multiplier core.
- `rsp_valid`  out  1: product available.
- `rsp_ready`  in  1: consumer accepts the product.
- `rsp_id`  out  ID_W: index of the requester that owns `rsp_p`.
- `rsp_p`  out  16: registered product.
- `busy`  out  1: high in every state except IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Selects a grant `g` among the asserted `req_valid` bits. The search is round-robin and starts at `ptr+1` mod `N_REQ`.
  - `req_ready[g]`=1 in the same cycle.
  - On handshake: `op_a`/`op_b` <= `req_a[g]`/`req_b[g]`, `id` <= g, `ptr` <= g, `cnt` <= `SETTLE_CYC`-1, then go to WAIT.
  - With no valid request, stay in IDLE.
- WAIT:
  - `mul_a`=`op_a` and `mul_b`=`op_b`, held stable.
  - When `cnt`==0: `rsp_p` <= `mul_p`, `rsp_id` <= `id`, `rsp_valid` <= 1, go to RESP. Otherwise `cnt` decrements.
- RESP:
  - `rsp_valid`, `rsp_id` and `rsp_p` are held until `rsp_valid && rsp_ready`.
  - After that handshake, `rsp_valid` <= 0 and the FSM goes to IDLE.
  - `req_ready` stays all-zero in WAIT and RESP.
- Arithmetic: the product is unsigned 8x8 -> 16 bits with no truncation. The block never modifies `mul_p`.
- Requesters must hold `req_a`/`req_b` stable while `req_valid` is high and `req_ready` is low.
- Reset values: `ptr`=`N_REQ`-1, so requester 0 wins first. `mul_a`=0, `mul_b`=0, `rsp_valid`=0, `rsp_p`=0, `rsp_id`=0, `busy`=0, state=IDLE.
- `req_ready` is forced to 0 while `rst_n` is low.
- Reset asserted mid-operation discards the operation; no response is issued for it.
- A requester that deasserts `req_valid` before being granted is simply skipped.

## Timing
- For a handshake in cycle T:
  - `mul_a`/`mul_b` are valid from T+1.
  - Capture happens at the end of cycle T+`SETTLE_CYC`.
  - `rsp_valid` rises in cycle T+`SETTLE_CYC`+1.
- With `rsp_ready` tied high, throughput is one operation per `SETTLE_CYC`+2 cycles.
- The next grant occurs in the IDLE cycle that follows the response handshake.
- The path from `mul_a`/`mul_b` to `mul_p` is a `SETTLE_CYC`-cycle multicycle path. Constraints are supplied with the block.

## Configuration
- `MULT_SHARE_ZERO_BYPASS_EN` defined:
  - If `req_a[g]`==0 or `req_b[g]`==0 at handshake, the FSM goes directly to RESP.
  - `rsp_p`=0 and `rsp_valid` rises at T+1.
  - `mul_a`/`mul_b` keep their previous values, which suppresses core toggling.
- `MULT_SHARE_ZERO_BYPASS_EN` undefined: every operation, including zero operands, passes through WAIT with full latency.

## Structure
- Shared package `mult_share_pkg` holds:
  - the state enum (IDLE, WAIT, RESP);
  - `OP_W`=8 and `PROD_W`=16;
  - the `SETTLE_CYC` legal-range constants.
- One sub-module, `rr_arbiter`:
  - inputs: `N_REQ`-wide request vector and pointer;
  - outputs: one-hot grant and grant index;
  - purely combinational.

## Test plan
- Reset, then requester 0 issues a=200, b=190 (`SETTLE_CYC`=2): `req_ready[0]` in the same cycle; `rsp_valid` 3 cycles later with `rsp_p`=38000 and `rsp_id`=0.
- All 4 requesters valid simultaneously (operands 144x89, 20x50, 249x153, 80x255, `rsp_ready`=1): grants in order 0,1,2,3; products 12816, 1000, 38097, 20400, each 4 cycles apart.
- 255x255 issued with `rsp_ready` held low for 5 cycles: `rsp_valid`, `rsp_p`=65025 and `rsp_id` stay stable; no new `req_ready` until the handshake.
- Requester 2 only, two back-to-back ops (2x223, 189x190): results 446 then 35910. The pointer lands on 2, so requester 3 wins over requester 0 on the next contention.
- Reset pulsed during WAIT on 100x100: no `rsp_valid`; all outputs return to reset values; the first post-reset grant goes to requester 0.
- 0x77 with the macro defined: `rsp_p`=0 at T+1 and `mul_a`/`mul_b` unchanged. Without the macro: `rsp_p`=0 at T+3.

Source files
------------

// File: rtl/mult_share_pkg.sv
// rtl/mult_share_pkg.sv - shared types and constants for the multiplier-sharing controller
package mult_share_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    // Legal range of the settle window; the counter is sized for the maximum
    localparam int SETTLE_MIN = 1;
    localparam int SETTLE_MAX = 15;
    localparam int CNT_W      = $clog2(SETTLE_MAX + 1);

endpackage

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// rtl/mult_share_ctrl_rr_arbiter.sv - combinational round-robin arbiter, search starts after ptr
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  gnt_idx
);

    int              idx;
    logic [ID_W-1:0] cand;
    logic            found;

    // Walk ptr+1 .. ptr+N_REQ (mod N_REQ) and take the first asserted request
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        cand    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx  = (int'(ptr) + k) % N_REQ;
            cand = ID_W'(idx);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                gnt_idx     = cand;
            end
        end
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// rtl/mult_share_ctrl.sv - round-robin issue controller sharing one 8x8 multiplier core (option: MULT_SHARE_ZERO_BYPASS_EN)
module mult_share_ctrl
    import mult_share_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int SETTLE_CYC = 2,
    parameter int ID_W       = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [OP_W*N_REQ-1:0] req_a,
    input  logic [OP_W*N_REQ-1:0] req_b,
    output logic [OP_W-1:0]       mul_a,
    output logic [OP_W-1:0]       mul_b,
    input  logic [PROD_W-1:0]     mul_p,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [PROD_W-1:0]     rsp_p,
    output logic                  busy
);

    state_t           state;
    state_t           state_nxt;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  id;
    logic [CNT_W-1:0] cnt;

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  gnt_idx;
    logic             any_req;
    logic [OP_W-1:0]  sel_a;
    logic [OP_W-1:0]  sel_b;
    logic             zero_op;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .grant   (grant),
        .gnt_idx (gnt_idx)
    );

    assign any_req = |grant;
    assign sel_a   = req_a[int'(gnt_idx)*OP_W +: OP_W];
    assign sel_b   = req_b[int'(gnt_idx)*OP_W +: OP_W];

`ifdef MULT_SHARE_ZERO_BYPASS_EN
    // A zero operand makes the product trivially zero, so the core is skipped
    assign zero_op = (sel_a == '0) || (sel_b == '0);
`else
    assign zero_op = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and combinational outputs; req_ready is gated by reset
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (rst_n) begin
                    req_ready = grant;
                end
                if (any_req) begin
                    state_nxt = zero_op ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand issue, settle countdown and product capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= ID_W'(N_REQ - 1);
            id        <= '0;
            cnt       <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_p     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        ptr <= gnt_idx;
                        id  <= gnt_idx;
                        cnt <= CNT_W'(SETTLE_CYC - 1);
                        if (zero_op) begin
                            rsp_p     <= '0;
                            rsp_id    <= gnt_idx;
                            rsp_valid <= 1'b1;
                        end else begin
                            mul_a <= sel_a;
                            mul_b <= sel_b;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        rsp_p     <= mul_p;
                        rsp_id    <= id;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb/tb_mult_share_ctrl.sv - self-checking bench for mult_share_ctrl with an operation-level model
module tb_mult_share_ctrl;

    localparam int N = 4;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [8*N-1:0] req_a = '0;
    logic [8*N-1:0] req_b = '0;
    logic [7:0]     mul_a;
    logic [7:0]     mul_b;
    logic [15:0]    mul_p;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic [1:0]     rsp_id;
    logic [15:0]    rsp_p;
    logic           busy;

    int n_chk  = 0;
    int n_pass = 0;

    // Event logs produced by the model: grants and completed responses
    int g_id[$];
    int g_cyc[$];
    int r_p[$];
    int r_id[$];
    int r_cyc[$];

    mult_share_ctrl #(
        .N_REQ      (N),
        .SETTLE_CYC (S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .busy      (busy)
    );

    // External multiplier core
    assign mul_p = 16'(mul_a) * 16'(mul_b);

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Operation-level model: one outstanding operation, response due at a known cycle
    int  cyc = 0;
    int  m_ptr = N - 1;
    bit  m_busy = 0;
    int  m_rsp_cyc = 0;
    int  m_exp_p = 0;
    int  m_exp_id = 0;
    int  m_last_p = 0;
    int  m_last_id = 0;
    int  m_mul_a = 0;
    int  m_mul_b = 0;

    always @(negedge clk) begin
        int  e_g;
        bit  e_any;
        bit  e_rv;
        bit  was_busy;
        bit  byp;
        int  a;
        int  b;
        int  idx;
        cyc++;
        if (!rst_n) begin
            chk("rst_req_ready", int'(req_ready), 0);
            chk("rst_rsp_valid", int'(rsp_valid), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_mul_a", int'(mul_a), 0);
            chk("rst_mul_b", int'(mul_b), 0);
            chk("rst_rsp_p", int'(rsp_p), 0);
            chk("rst_rsp_id", int'(rsp_id), 0);
            m_ptr = N - 1; m_busy = 0; m_last_p = 0; m_last_id = 0;
            m_mul_a = 0; m_mul_b = 0;
        end else begin
            e_any = 0; e_g = 0;
            if (!m_busy) begin
                for (int k = 1; k <= N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (!e_any && (((req_valid >> idx) & 1) != 0)) begin
                        e_any = 1; e_g = idx;
                    end
                end
            end
            e_rv = m_busy && (cyc >= m_rsp_cyc);
            chk("req_ready", int'(req_ready), e_any ? (1 << e_g) : 0);
            chk("rsp_valid", int'(rsp_valid), int'(e_rv));
            chk("busy", int'(busy), int'(m_busy));
            chk("mul_a", int'(mul_a), m_mul_a);
            chk("mul_b", int'(mul_b), m_mul_b);
            chk("rsp_p", int'(rsp_p), e_rv ? m_exp_p : m_last_p);
            chk("rsp_id", int'(rsp_id), e_rv ? m_exp_id : m_last_id);

            was_busy = m_busy;
            if (e_rv && rsp_ready) begin
                r_p.push_back(m_exp_p); r_id.push_back(m_exp_id); r_cyc.push_back(cyc);
                m_busy = 0; m_last_p = m_exp_p; m_last_id = m_exp_id;
            end
            if (!was_busy && e_any) begin
                a = int'(req_a[e_g*8 +: 8]);
                b = int'(req_b[e_g*8 +: 8]);
                g_id.push_back(e_g); g_cyc.push_back(cyc);
`ifdef MULT_SHARE_ZERO_BYPASS_EN
                byp = (a == 0) || (b == 0);
`else
                byp = 0;
`endif
                m_busy = 1; m_ptr = e_g; m_exp_id = e_g; m_exp_p = a * b;
                if (byp) begin
                    m_rsp_cyc = cyc + 1;
                end else begin
                    m_rsp_cyc = cyc + S + 1;
                    m_mul_a = a; m_mul_b = b;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; req_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*8 +: 8] = 8'(a);
        req_b[i*8 +: 8] = 8'(b);
        req_valid[i] = 1'b1;
    endtask

    // Requesters drop valid once their handshake is seen
    task automatic wait_grants(input int n);
        int got = 0;
        int budget = 60;
        logic [N-1:0] hs;
        while (got < n && budget > 0) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk); #1;
            req_valid = req_valid & ~hs;
            got += $countones(hs);
            budget--;
        end
        if (got < n) chk("grant_timeout", got, n);
    endtask

    task automatic wait_resps(input int target);
        int budget = 60;
        while (r_p.size() < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        @(posedge clk); #1;
        if (r_p.size() < target) chk("resp_timeout", r_p.size(), target);
    endtask

    initial begin
        int gb;
        int rb;
        int pr[4];
        pr = '{12816, 1000, 38097, 20400};

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single operation from requester 0
        gb = g_id.size(); rb = r_p.size();
        set_op(0, 200, 190);
        wait_grants(1);
        wait_resps(rb + 1);
        if (r_p.size() > rb && g_id.size() > gb) begin
            chk("t1_gid", g_id[gb], 0);
            chk("t1_p", r_p[rb], 38000);
            chk("t1_id", r_id[rb], 0);
            chk("t1_lat", r_cyc[rb] - g_cyc[gb], 3);
        end

        // Four requesters contending
        do_reset();
        gb = g_id.size(); rb = r_p.size();
        set_op(0, 144, 89); set_op(1, 20, 50); set_op(2, 249, 153); set_op(3, 80, 255);
        wait_grants(4);
        wait_resps(rb + 4);
        if (r_p.size() >= rb + 4 && g_id.size() >= gb + 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("t2_gid", g_id[gb + k], k);
                chk("t2_p", r_p[rb + k], pr[k]);
                if (k > 0) chk("t2_spacing", r_cyc[rb + k] - r_cyc[rb + k - 1], 4);
            end
        end

        // Back-pressure on the response channel
        do_reset();
        gb = g_id.size(); rb = r_p.size();
        rsp_ready = 1'b0;
        set_op(1, 255, 255); set_op(2, 3, 5);
        wait_grants(1);
        repeat (7) @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_grants(1);
        wait_resps(rb + 2);
        if (r_p.size() >= rb + 2 && g_id.size() >= gb + 2) begin
            chk("t3_p", r_p[rb], 65025);
            chk("t3_id", r_id[rb], 1);
            chk("t3_lat", r_cyc[rb] - g_cyc[gb], 8);
            chk("t3_next_grant", g_cyc[gb + 1] - g_cyc[gb], 9);
            chk("t3_gid2", g_id[gb + 1], 2);
            chk("t3_p2", r_p[rb + 1], 15);
        end

        // Requester 2 back-to-back, then pointer decides 3 over 0
        do_reset();
        gb = g_id.size(); rb = r_p.size();
        set_op(2, 2, 223);
        wait_grants(1);
        set_op(2, 189, 190);
        wait_grants(1);
        wait_resps(rb + 2);
        set_op(0, 1, 1); set_op(3, 4, 4);
        wait_grants(1);
        if (r_p.size() >= rb + 2 && g_id.size() >= gb + 3) begin
            chk("t4_p0", r_p[rb], 446);
            chk("t4_p1", r_p[rb + 1], 35910);
            chk("t4_gid", g_id[gb + 2], 3);
        end
        wait_grants(1);
        wait_resps(rb + 4);

        // Reset in the middle of the settle window
        do_reset();
        gb = g_id.size(); rb = r_p.size();
        set_op(0, 100, 100);
        wait_grants(1);
        rst_n = 1'b0;
        req_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("t5_no_resp", r_p.size(), rb);
        set_op(0, 7, 9); set_op(1, 6, 6);
        wait_grants(1);
        if (g_id.size() >= gb + 2) chk("t5_gid", g_id[gb + 1], 0);
        wait_grants(1);
        wait_resps(rb + 2);

        // Zero operand
        do_reset();
        gb = g_id.size(); rb = r_p.size();
        set_op(0, 12, 13);
        wait_grants(1);
        wait_resps(rb + 1);
        set_op(0, 0, 8'h77);
        wait_grants(1);
        wait_resps(rb + 2);
        if (r_p.size() >= rb + 2 && g_id.size() >= gb + 2) begin
            chk("t6_p", r_p[rb + 1], 0);
`ifdef MULT_SHARE_ZERO_BYPASS_EN
            chk("t6_lat", r_cyc[rb + 1] - g_cyc[gb + 1], 1);
            chk("t6_mul_a", int'(mul_a), 12);
            chk("t6_mul_b", int'(mul_b), 13);
`else
            chk("t6_lat", r_cyc[rb + 1] - g_cyc[gb + 1], 3);
            chk("t6_mul_a", int'(mul_a), 0);
            chk("t6_mul_b", int'(mul_b), 8'h77);
`endif
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
